if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that feeds the decode-stage immediate generator and register file. Honours load-use stalls from the hazard unit and flushes on taken branches resolved in ID.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_register.sv | 41 ++++
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_W = 32;

    // addi x0,x0,0: the canonical bubble placed in IF/ID on reset and flush.
    localparam logic [INSTR_W-1:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_C = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Program-counter register: reset, redirect to an aligned target, hold, or step by 4.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_C
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            hold_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            unused_target_lsbs;

    // Misaligned targets are not trapped; the low two bits are simply dropped.
    assign unused_target_lsbs = ^target_i[1:0];

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {target_i[XLEN-1:2], 2'b00};
        end else if (!hold_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem address, IF/ID register.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module if_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0]    RESET_PC  = RESET_PC_C,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [XLEN-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [XLEN-1:0]    branch_target_i,
    output logic [XLEN-1:0]    if_id_pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic               if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

    logic [XLEN-1:0] pc;
    if_id_t          if_id_q;
    if_id_t          if_id_d;

    // A taken branch overrides a stall, so the PC only holds on a plain stall.
    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .redirect_i (branch_taken_i),
        .target_i   (branch_target_i),
        .hold_i     (stall_i),
        .pc_o       (pc)
    );

    assign imem_addr_o = pc;

    always_comb begin
        if_id_d = if_id_q;
        if (branch_taken_i) begin
            if_id_d = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (!stall_i) begin
            if_id_d = '{pc: pc, instr: imem_data_i, valid: 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_i && !branch_taken_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_taken_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, then random traffic against a rule-level model.
module tb_if_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PAT     = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;

    logic [31:0] addr_a, data_a, id_pc_a, id_instr_a;
    logic        id_valid_a;
    logic [31:0] addr_b, data_b, id_pc_b, id_instr_b;
    logic        id_valid_b;

    int n_vec = 0;
    int n_err = 0;

    // imem model: every word is a function of its address.
    assign data_a = addr_a ^ PAT;
    assign data_b = addr_b ^ PAT;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

    if_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_addr_o     (addr_a),
        .imem_data_i     (data_a),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .if_id_pc_o      (id_pc_a),
        .if_id_instr_o   (id_instr_a),
        .if_id_valid_o   (id_valid_a)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o     (scnt_a),
        .flush_cnt_o     (fcnt_a)
`endif
    );

    if_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_addr_o     (addr_b),
        .imem_data_i     (data_b),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .if_id_pc_o      (id_pc_b),
        .if_id_instr_o   (id_instr_b),
        .if_id_valid_o   (id_valid_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o     (scnt_b),
        .flush_cnt_o     (fcnt_b)
`endif
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural state only, updated by the stated priority rules.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic        id_valid;
        longint      stalls;
        longint      flushes;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_next(model_t s, logic [31:0] rpc, logic r, logic st,
                                          logic b, logic [31:0] t);
        model_t n = s;
        if (r) begin
            n.pc = rpc; n.id_pc = 0; n.id_instr = NOP; n.id_valid = 0;
            n.stalls = 0; n.flushes = 0;
        end else if (b) begin
            n.pc = (t / 4) * 4;
            n.id_pc = 0; n.id_instr = NOP; n.id_valid = 0;
            n.flushes = s.flushes + 1;
        end else if (st) begin
            n.stalls = s.stalls + 1;
        end else begin
            n.id_pc = s.pc; n.id_instr = s.pc ^ PAT; n.id_valid = 1;
            n.pc = 32'((64'(s.pc) + 4) % 64'h1_0000_0000);
        end
        return n;
    endfunction

    // scoreboard comparison
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("a.pc",    addr_a,             m_a.pc);
        chk("a.idpc",  id_pc_a,            m_a.id_pc);
        chk("a.instr", id_instr_a,         m_a.id_instr);
        chk("a.valid", 32'(id_valid_a),    32'(m_a.id_valid));
        chk("b.pc",    addr_b,             m_b.pc);
        chk("b.idpc",  id_pc_b,            m_b.id_pc);
        chk("b.instr", id_instr_b,         m_b.id_instr);
        chk("b.valid", 32'(id_valid_b),    32'(m_b.id_valid));
`ifdef FETCH_PERF_CNT_EN
        chk("a.scnt", scnt_a, 32'(m_a.stalls));
        chk("a.fcnt", fcnt_a, 32'(m_a.flushes));
        chk("b.scnt", scnt_b, 32'(m_b.stalls));
        chk("b.fcnt", fcnt_b, 32'(m_b.flushes));
`endif
    endtask

    // driver: apply one cycle of inputs, advance the model, sample 1ns after the edge
    task automatic drive(input logic r, input logic st, input logic b, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = st; br = b; tgt = t;
        @(posedge clk);
        m_a = model_next(m_a, 32'h0, r, st, b, t);
        m_b = model_next(m_b, WRAP_PC, r, st, b, t);
        #1;
        chk_model();
    endtask

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic [31:0] exp_pc, exp_id_pc, exp_instr;
        logic        exp_valid;
        logic [31:0] exp_wrap_pc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
        m_a = '{default: 0};
        m_b = '{default: 0};

        //           rst stall br  tgt            pc            id_pc         instr         v     wrap pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h0,        32'h0,        NOP,          1'b0, 32'hFFFF_FFF8};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h4,        32'h0,        32'hA5A5_0000, 1'b1, 32'hFFFF_FFFC};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h8,        32'h4,        32'hA5A5_0004, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h8,        32'h4,        32'hA5A5_0004, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h8,        32'h4,        32'hA5A5_0004, 1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h8,        32'h4,        32'hA5A5_0004, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'hC,        32'h8,        32'hA5A5_0008, 1'b1, 32'h0000_0004};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h10,       32'hC,        32'hA5A5_000C, 1'b1, 32'h0000_0008};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h103,   32'h100,      32'h0,        NOP,          1'b0, 32'h0000_0100};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h104,      32'h100,      32'hA5A5_0100, 1'b1, 32'h0000_0104};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h203,   32'h200,      32'h0,        NOP,          1'b0, 32'h0000_0200};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h204,      32'h200,      32'hA5A5_0200, 1'b1, 32'h0000_0204};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h204,      32'h200,      32'hA5A5_0200, 1'b1, 32'h0000_0204};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h55,    32'h0,        32'h0,        NOP,          1'b0, 32'hFFFF_FFF8};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h4,        32'h0,        32'hA5A5_0000, 1'b1, 32'hFFFF_FFFC};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            chk($sformatf("v%0d.pc", i),    addr_a,          vecs[i].exp_pc);
            chk($sformatf("v%0d.idpc", i),  id_pc_a,         vecs[i].exp_id_pc);
            chk($sformatf("v%0d.instr", i), id_instr_a,      vecs[i].exp_instr);
            chk($sformatf("v%0d.valid", i), 32'(id_valid_a), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d.wpc", i),   addr_b,          vecs[i].exp_wrap_pc);
`ifdef FETCH_PERF_CNT_EN
            if (i == 10) begin
                chk("v10.fcnt", fcnt_a, 32'd2);
                chk("v10.scnt", scnt_a, 32'd3);
            end
            if (i == 13) begin
                chk("v13.fcnt", fcnt_a, 32'd0);
                chk("v13.scnt", scnt_a, 32'd0);
            end
`endif
        end

        // Long stall followed by a branch that lands near the top of the address space.
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomised traffic checked against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
